// File: rtl/sram_access_arbiter.sv
// Round-robin SRAM ownership arbiter with S_IDLE / S_OWNED / S_DRAIN sequencing.
// Optional idle-owner watchdog is compiled in with `define SRAM_ARB_WATCHDOG_EN.

module sram_arb_client #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 16
) (
  input  logic              sel,
  input  logic              req,
  input  logic              rel,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              we_n,
  output logic [ADDR_W-1:0] sel_addr,
  output logic [DATA_W-1:0] sel_wdata,
  output logic              sel_wr,
  output logic              sel_end
);
  // Each lane contributes to an AND-OR mux; only the granted lane is non-zero.
  assign sel_addr  = sel ? addr  : '0;
  assign sel_wdata = sel ? wdata : '0;
  assign sel_wr    = sel & ~we_n;
  assign sel_end   = sel & (rel | ~req);
endmodule

module sram_access_arbiter #(
  parameter int NUM_CLIENTS = 4,
  parameter int ADDR_W      = 18,
  parameter int DATA_W      = 16,
  parameter int WDOG_CYCLES = 50000000
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_CLIENTS-1:0]          req,
  input  logic [NUM_CLIENTS-1:0]          client_release,
  input  logic [NUM_CLIENTS*ADDR_W-1:0]   client_address,
  input  logic [NUM_CLIENTS*DATA_W-1:0]   client_write_data,
  input  logic [NUM_CLIENTS-1:0]          client_we_n,
  output logic [NUM_CLIENTS-1:0]          grant,
  output logic [$clog2(NUM_CLIENTS)-1:0]  owner,
  output logic                            busy,
  output logic [ADDR_W-1:0]               sram_address,
  output logic [DATA_W-1:0]               sram_write_data,
  output logic                            sram_we_n,
  output logic                            timeout
);
  localparam int PTR_W = $clog2(NUM_CLIENTS);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_OWNED = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  if (NUM_CLIENTS < 2 || NUM_CLIENTS > 8 || WDOG_CYCLES < 2) begin : g_param_check
    $error("sram_access_arbiter: unsupported parameter set");
  end

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              we_n;
  } sram_req_t;

  logic [1:0]             state_q, state_d;
  logic [NUM_CLIENTS-1:0] grant_q, grant_d;
  logic [PTR_W-1:0]       owner_q, owner_d;
  logic [PTR_W-1:0]       rr_q, rr_d;
  logic [ADDR_W-1:0]      hold_q, hold_d;
  logic [PTR_W-1:0]       pick;
  logic                   owner_end;
  logic                   wdog_fire;

  logic [NUM_CLIENTS-1:0][ADDR_W-1:0] lane_addr;
  logic [NUM_CLIENTS-1:0][DATA_W-1:0] lane_wdata;
  logic [NUM_CLIENTS-1:0]             lane_wr;
  logic [NUM_CLIENTS-1:0]             lane_end;
  sram_req_t                          own_req;
  sram_req_t                          sram_req;

  for (genvar i = 0; i < NUM_CLIENTS; i++) begin : g_lane
    sram_arb_client #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
    ) u_client (
      .sel       (grant_q[i]),
      .req       (req[i]),
      .rel       (client_release[i]),
      .addr      (client_address[i*ADDR_W +: ADDR_W]),
      .wdata     (client_write_data[i*DATA_W +: DATA_W]),
      .we_n      (client_we_n[i]),
      .sel_addr  (lane_addr[i]),
      .sel_wdata (lane_wdata[i]),
      .sel_wr    (lane_wr[i]),
      .sel_end   (lane_end[i])
    );
  end

  always_comb begin
    own_req.addr  = '0;
    own_req.wdata = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      own_req.addr  = own_req.addr  | lane_addr[i];
      own_req.wdata = own_req.wdata | lane_wdata[i];
    end
    own_req.we_n = ~|lane_wr;
  end

  assign owner_end = |lane_end;

  // Walk downward so the nearest requester above rr_q is the last (winning) write.
  always_comb begin
    int idx;
    pick = rr_q;
    idx  = 0;
    for (int k = NUM_CLIENTS; k >= 1; k--) begin
      idx = (int'(rr_q) + k) % NUM_CLIENTS;
      if (req[idx]) pick = PTR_W'(idx);
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    hold_d  = hold_q;
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          state_d       = S_OWNED;
          grant_d       = '0;
          grant_d[pick] = 1'b1;
          owner_d       = pick;
          rr_d          = pick;
        end
      end
      S_OWNED: begin
        hold_d = own_req.addr;
        if (owner_end || wdog_fire) begin
          state_d = S_DRAIN;
          grant_d = '0;
        end
      end
      S_DRAIN: state_d = S_IDLE;
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      owner_q <= '0;
      rr_q    <= PTR_W'(NUM_CLIENTS - 1);
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      hold_q  <= hold_d;
    end
  end

`ifdef SRAM_ARB_WATCHDOG_EN
  localparam int CNT_W = $clog2(WDOG_CYCLES + 1);

  logic [CNT_W-1:0] wdog_q, wdog_d;
  logic             timeout_q, timeout_d;

  // Any owner write restarts the idle count; an explicit release wins over a timeout.
  always_comb begin
    wdog_d    = '0;
    wdog_fire = 1'b0;
    if (state_q == S_OWNED && own_req.we_n) begin
      wdog_d    = wdog_q + 1'b1;
      wdog_fire = !owner_end && (wdog_q == CNT_W'(WDOG_CYCLES - 1));
    end
    timeout_d = wdog_fire;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdog_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      wdog_q    <= wdog_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign wdog_fire = 1'b0;
  assign timeout   = 1'b0;
`endif

  always_comb begin
    sram_req.addr  = client_address[ADDR_W-1:0];
    sram_req.wdata = '0;
    sram_req.we_n  = 1'b1;
    case (state_q)
      S_OWNED: sram_req = own_req;
      S_DRAIN: sram_req.addr = hold_q;
      default: ;
    endcase
    // Reset blocks writes combinationally, ahead of the async state clear.
    if (rst) sram_req.we_n = 1'b1;
  end

  assign grant           = grant_q;
  assign owner           = owner_q;
  assign busy            = (state_q == S_OWNED) || (state_q == S_DRAIN);
  assign sram_address    = sram_req.addr;
  assign sram_write_data = sram_req.wdata;
  assign sram_we_n       = sram_req.we_n;
endmodule

// File: tb/tb_sram_access_arbiter.sv
// Directed + random bench for sram_access_arbiter against a behavioural ownership model.
module tb_sram_access_arbiter;
  localparam int N  = 4;
  localparam int AW = 18;
  localparam int DW = 16;
  localparam int WD = 16;
`ifdef SRAM_ARB_WATCHDOG_EN
  localparam bit WDOG_EN = 1'b1;
`else
  localparam bit WDOG_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req, rel, we_bus;
  logic [AW-1:0] c_addr [N];
  logic [DW-1:0] c_wd   [N];
  logic          c_we   [N];
  logic [N*AW-1:0] addr_bus;
  logic [N*DW-1:0] wd_bus;

  logic [N-1:0]  grant;
  logic [1:0]    owner;
  logic          busy, sram_we_n, timeout;
  logic [AW-1:0] sram_address;
  logic [DW-1:0] sram_write_data;

  int n_cmp = 0;
  int n_bad = 0;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      addr_bus[i*AW +: AW] = c_addr[i];
      wd_bus[i*DW +: DW]   = c_wd[i];
      we_bus[i]            = c_we[i];
    end
  end

  sram_access_arbiter #(
    .NUM_CLIENTS (N),
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .WDOG_CYCLES (WD)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .req               (req),
    .client_release    (rel),
    .client_address    (addr_bus),
    .client_write_data (wd_bus),
    .client_we_n       (we_bus),
    .grant             (grant),
    .owner             (owner),
    .busy              (busy),
    .sram_address      (sram_address),
    .sram_write_data   (sram_write_data),
    .sram_we_n         (sram_we_n),
    .timeout           (timeout)
  );

  always #5 clk = ~clk;

  // Model: who owns the SRAM, whether we are in the drain gap, last grant, idle count.
  bit          m_owned, m_drain, m_to;
  int          m_own, m_rr, m_cnt;
  logic [AW-1:0] m_hold;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_owned = 0; m_drain = 0; m_to = 0;
    m_own = 0; m_rr = N - 1; m_cnt = 0; m_hold = '0;
  endtask

  // Compare outputs against the model for the current cycle, then advance the model.
  task automatic tick();
    logic [N-1:0] e_grant;
    bit to_n;
    #2;
    if (rst) m_reset();
    e_grant = '0;
    if (m_owned) e_grant[m_own] = 1'b1;
    chk("grant", grant, e_grant);
    chk("owner", owner, m_own);
    chk("busy", busy, m_owned | m_drain);
    chk("timeout", timeout, m_to);
    chk("sram_address", sram_address, m_owned ? c_addr[m_own] : (m_drain ? m_hold : c_addr[0]));
    chk("sram_write_data", sram_write_data, m_owned ? c_wd[m_own] : '0);
    chk("sram_we_n", sram_we_n, m_owned ? c_we[m_own] : 1'b1);
    if (!rst) begin
      to_n = 0;
      if (m_owned) begin
        if (rel[m_own] || !req[m_own]) begin
          m_owned = 0; m_drain = 1; m_hold = c_addr[m_own];
        end else if (WDOG_EN && c_we[m_own] && m_cnt == WD - 1) begin
          m_owned = 0; m_drain = 1; m_hold = c_addr[m_own]; to_n = 1;
        end else begin
          m_cnt = c_we[m_own] ? m_cnt + 1 : 0;
        end
      end else if (m_drain) begin
        m_drain = 0;
      end else if (req != '0) begin
        for (int k = 1; k <= N; k++) begin
          if (req[(m_rr + k) % N]) begin
            m_own = (m_rr + k) % N;
            break;
          end
        end
        m_rr = m_own; m_owned = 1; m_cnt = 0;
      end
      m_to = to_n;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1; req = '0; rel = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench did not finish");
  end

  initial begin
    int order[$];
    int exp_order[4];
    int owned_n, gap, to_n, to_at, exp_owned, exp_to;

    exp_order = '{1, 2, 3, 1};
    m_reset();
    for (int i = 0; i < N; i++) begin
      c_addr[i] = '0; c_wd[i] = '0; c_we[i] = 1'b1;
    end

    // Reset state with client 0 address visible on the bus.
    rst = 1'b1; req = '0; rel = '0;
    c_addr[0] = 18'h23E00;
    #2;
    chk("rst_grant", grant, 0);
    chk("rst_we_n", sram_we_n, 1);
    chk("rst_addr", sram_address, 32'h23E00);
    chk("rst_busy", busy, 0);
    chk("rst_owner", owner, 0);
    chk("rst_timeout", timeout, 0);
    tick();
    tick();
    rst = 1'b0;

    // Round robin over three held requesters, each releasing on its third owned cycle.
    c_addr[1] = 18'h01111; c_addr[2] = 18'h02222; c_addr[3] = 18'h03333;
    req = 4'b1110;
    owned_n = 0; gap = 0;
    for (int cyc = 0; cyc < 80 && order.size() < 4; cyc++) begin
      rel = '0;
      if (grant != '0) begin
        owned_n++;
        if (owned_n == 1) begin
          if (order.size() > 0) chk("rr_gap", gap, 2);
          order.push_back(int'(owner));
        end
        if (owned_n == 3) rel = grant;
        gap = 0;
      end else begin
        owned_n = 0;
        gap++;
        if (busy) chk("drain_we_n", sram_we_n, 1);
      end
      tick();
    end
    rel = '0;
    chk("rr_count", order.size(), 4);
    foreach (order[i]) if (i < 4) chk("rr_order", order[i], exp_order[i]);

    // Single requester: grant one cycle later, its write appears on the bus.
    reset_dut();
    req = 4'b0100; c_addr[2] = 18'h00100; c_we[2] = 1'b0; c_wd[2] = 16'hBEEF;
    tick();
    chk("one_grant", grant, 4'b0100);
    chk("one_addr", sram_address, 32'h00100);
    chk("one_we_n", sram_we_n, 0);
    chk("one_wdata", sram_write_data, 32'hBEEF);

    // Non-owner release pulse leaves owner 1 untouched.
    req = '0; c_we[2] = 1'b1;
    tick();
    req = 4'b0010; c_addr[1] = 18'h2AAAA; c_wd[1] = 16'h1234; c_we[1] = 1'b0;
    for (int k = 0; k < 8 && grant != 4'b0010; k++) tick();
    chk("own1_grant", grant, 4'b0010);
    req = 4'b0110; rel = 4'b0100;
    tick();
    rel = '0;
    chk("nonown_grant", grant, 4'b0010);
    chk("nonown_addr", sram_address, 32'h2AAAA);
    chk("nonown_wdata", sram_write_data, 32'h1234);
    chk("nonown_we_n", sram_we_n, 0);
    tick();
    chk("nonown_grant2", grant, 4'b0010);

    // Reset asserted mid-cycle while client 3 is writing.
    reset_dut();
    req = 4'b1000; c_addr[3] = 18'h3FFFF; c_we[3] = 1'b0;
    tick();
    chk("wr3_grant", grant, 4'b1000);
    chk("wr3_we_n", sram_we_n, 0);
    #3;
    rst = 1'b1;
    #1;
    chk("async_we_n", sram_we_n, 1);
    chk("async_grant", grant, 0);
    chk("async_owner", owner, 0);
    chk("async_busy", busy, 0);
    tick();
    tick();
    rst = 1'b0; req = '0; c_we[3] = 1'b1; c_we[1] = 1'b1;
    tick();
    chk("post_rst_grant", grant, 0);
    chk("post_rst_owner", owner, 0);

    // Idle owner holding the bus: watchdog release when enabled, indefinite hold otherwise.
    reset_dut();
    req = 4'b0001;
    owned_n = 0; to_n = 0; to_at = -10;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (grant != '0) owned_n++;
      if (cyc == to_at + 1) chk("wdog_busy_fall", busy, 0);
      if (timeout) begin
        to_n++;
        to_at = cyc;
        chk("wdog_to_grant", grant, 0);
        chk("wdog_to_busy", busy, 1);
        req = '0;
      end
      tick();
    end
    exp_owned = WDOG_EN ? 16 : 39;
    exp_to    = WDOG_EN ? 1 : 0;
    chk("wdog_owned_cycles", owned_n, exp_owned);
    chk("wdog_pulses", to_n, exp_to);

    // Random traffic against the model.
    reset_dut();
    for (int cyc = 0; cyc < 900; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(7) == 0) req[i] = ~req[i];
        rel[i]    = ($urandom_range(15) == 0);
        c_addr[i] = AW'($urandom);
        c_wd[i]   = DW'($urandom);
        c_we[i]   = ($urandom_range(3) != 0);
      end
      if (rst) rst = 1'b0;
      else if ($urandom_range(299) == 0) rst = 1'b1;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/sram_access_arbiter.md
SRAM_ACCESS_ARBITER -- requirements
Module: sram_access_arbiter

Interface
REQ-001 Parameter NUM_CLIENTS, default 4, number of SRAM requesters (2..8); client 0 is the display/default client.
REQ-002 Parameter ADDR_W, default 18, SRAM word-address width.
REQ-003 Parameter DATA_W, default 16, SRAM data width.
REQ-004 Parameter WDOG_CYCLES, default 50000000, number of idle owner cycles before forced release.
REQ-005 Clock  input  1  system clock; all state updates on its rising edge.
REQ-006 Reset  input  1  asynchronous, active-high reset.
REQ-007 Req  input  NUM_CLIENTS  per-client access request, level.
REQ-008 Release  input  NUM_CLIENTS  per-client single-cycle release pulse.
REQ-009 Client_address  input  NUM_CLIENTS*ADDR_W  packed client addresses, client i in bits [i*ADDR_W +: ADDR_W].
REQ-010 Client_write_data  input  NUM_CLIENTS*DATA_W  packed client write data.
REQ-011 Client_we_n  input  NUM_CLIENTS  per-client active-low write enable.
REQ-012 Grant  output  NUM_CLIENTS  one-hot ownership, registered.
REQ-013 Owner  output  $clog2(NUM_CLIENTS)  index of current or last owner, registered.
REQ-014 Busy  output  1  high while in S_OWNED or S_DRAIN.
REQ-015 SRAM_address  output  ADDR_W  muxed address to the SRAM controller.
REQ-016 SRAM_write_data  output  DATA_W  muxed write data.
REQ-017 SRAM_we_n  output  1  muxed active-low write enable.
REQ-018 Timeout  output  1  single-cycle pulse on watchdog release.

Function
REQ-019 The FSM SHALL have states S_IDLE, S_OWNED and S_DRAIN.
REQ-020 In S_IDLE, the block SHALL drive SRAM_address from client 0, SRAM_write_data 0, SRAM_we_n 1, and Grant 0.
REQ-021 In S_IDLE with any Req bit high, the block SHALL select the first requesting client searching upward from (rr_ptr+1) mod NUM_CLIENTS, register Owner, assert Grant one-hot, and enter S_OWNED on the next edge (latency 1 cycle).
REQ-022 On each grant, rr_ptr SHALL be set to the granted index, so a continuously requesting client cannot starve others.
REQ-023 In S_OWNED, SRAM_address, SRAM_write_data and SRAM_we_n SHALL be combinational copies of the Owner client's inputs; Grant SHALL remain stable.
REQ-024 In S_OWNED, Release[Owner]=1 or Req[Owner]=0 SHALL move the FSM to S_DRAIN and clear Grant on the same edge.
REQ-025 Release or Req activity from non-owner clients SHALL NOT affect the current ownership.
REQ-026 S_DRAIN SHALL last exactly one cycle with SRAM_we_n forced to 1 and the address held from the last owner, then the FSM SHALL return to S_IDLE.
REQ-027 After a release, the minimum time from the release edge to the next Grant SHALL be 2 cycles (S_DRAIN then S_IDLE arbitration).
REQ-028 Requests arriving in the same cycle as a release SHALL be arbitrated only in the following S_IDLE.

Reset
REQ-029 While Reset is high, the FSM SHALL be in S_IDLE, Grant 0, Owner 0, rr_ptr NUM_CLIENTS-1, Busy 0, Timeout 0, and watchdog counter 0.
REQ-030 Reset asserted mid-ownership SHALL force SRAM_we_n to 1 without waiting for a clock edge; no write may be issued during or after the reset.

Configuration
REQ-031 With SRAM_ARB_WATCHDOG_EN defined, a counter of width $clog2(WDOG_CYCLES+1) SHALL increment each S_OWNED cycle and clear on any cycle with owner we_n=0 and on entry to S_OWNED.
REQ-032 With SRAM_ARB_WATCHDOG_EN defined, when the counter reaches WDOG_CYCLES-1, the FSM SHALL enter S_DRAIN, clear Grant, and pulse Timeout for 1 cycle.
REQ-033 Without SRAM_ARB_WATCHDOG_EN, the block SHALL contain no counter, Timeout SHALL be tied to 0, and ownership SHALL end only per REQ-024.

Verification
REQ-034 Reset high, Req=4'b0000, Client_address[0]=0x23E00 -> Grant=0, SRAM_we_n=1, SRAM_address=0x23E00, Busy=0.
REQ-035 Req=4'b0100 in S_IDLE -> Grant=4'b0100 one cycle later; client 2 address 0x00100 with we_n=0 appears on SRAM_address and SRAM_we_n.
REQ-036 Req=4'b1110 held, each owner releases after 3 cycles -> grant order 1,2,3,1 with Grant gaps of exactly 2 cycles and SRAM_we_n=1 in every S_DRAIN cycle.
REQ-037 Owner 1 active, Release=4'b0100 pulse -> Grant stays 4'b0010 and SRAM outputs are unchanged.
REQ-038 Owner 3 writing with we_n=0, Reset asserted mid-cycle -> SRAM_we_n=1 immediately, Grant=0 and Owner=0 after reset.
REQ-039 With SRAM_ARB_WATCHDOG_EN defined and WDOG_CYCLES=16, owner holds Req with we_n=1 -> Timeout pulses once after 16 owned cycles, then Grant=0 and Busy falls one cycle later.
